div: RTL
========

DIV -- requirements
Module: div

Interface
REQ-001 SHALL have no parameters; the operand width is fixed at 32 bits and the result width at 64 bits.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port: rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: signed_div_i  input  1  1 = signed divide (DIV), 0 = unsigned divide (DIVU).
REQ-005 SHALL have port: opdata1_i  input  32  dividend.
REQ-006 SHALL have port: opdata2_i  input  32  divisor.
REQ-007 SHALL have port: start_i  input  1  division request from the EX stage.
REQ-008 SHALL have port: annul_i  input  1  cancel the in-flight division.
REQ-009 SHALL have port: result_o  output  64  {remainder[63:32], quotient[31:0]}.
REQ-010 SHALL have port: ready_o  output  1  result_o is valid.

Function
REQ-011 SHALL implement a four-state FSM: FREE, BYZERO, ON, END.
REQ-012 SHALL drive result_o and ready_o from registers only.
REQ-013 In FREE, when start_i=1 and annul_i=0, SHALL latch both operands and take one of two paths:
- opdata2_i=0: go to BYZERO.
- otherwise: go to ON and clear the iteration counter cnt (6 bits).
REQ-014 In FREE, when start_i=0 or annul_i=1, SHALL stay in FREE with ready_o=0 and result_o=0.
REQ-015 On acceptance with signed_div_i=1, SHALL latch the two's-complement absolute value of each negative operand.
REQ-016 SHALL keep a 65-bit working register; on entry to ON it SHALL hold {32'h0, |dividend|, 1'b0}.
REQ-017 In ON with cnt<32, each cycle SHALL form diff = work[63:32] - divisor as a 33-bit value, then:
- diff negative: work <= work<<1 (shifted-in bit 0).
- otherwise: work <= {diff[31:0], work[31:0], 1'b1}.
- cnt SHALL increment in both cases.
REQ-018 In ON with cnt=32, SHALL apply sign correction and go to END.
- quotient = work[31:0], negated when signed and the operand signs differ.
- remainder = work[64:33], negated when signed and the dividend is negative.
REQ-019 In ON, annul_i=1 SHALL return the FSM to FREE at the next edge, with ready_o=0, result_o=0 and cnt=0; a pending start_i SHALL then be accepted only from FREE.
REQ-020 In ON, changes on start_i, opdata1_i, opdata2_i and signed_div_i SHALL have no effect.
REQ-021 BYZERO SHALL go to END after one cycle with result_o=64'h0.
REQ-022 In END, SHALL drive ready_o=1 and hold result_o for as long as start_i=1.
REQ-023 In END, start_i=0 SHALL return the FSM to FREE at the next edge, with ready_o=0 and result_o=0.
REQ-024 Latency: with start accepted at edge E0, ready_o SHALL rise after edge E33 in the normal case and after edge E1 in the divide-by-zero case.
REQ-025 Signed -2^31 / -1 SHALL produce quotient 32'h80000000 (wrap) and remainder 0, with no exception.
REQ-026 When start_i=1 and annul_i=1 arrive in the same FREE cycle, annul_i SHALL win and the FSM SHALL stay in FREE.

Reset
REQ-027 While rst=1, without waiting for clk, SHALL force state=FREE, cnt=0, work=0, ready_o=0 and result_o=64'h0.
REQ-028 Reset asserted mid-ON or in END SHALL discard the operation; after release, the first accepted start SHALL be treated as a new division.

Verification
REQ-029 Unsigned 100/7, start held -> ready_o rises 33 edges after acceptance; result_o=64'h00000002_0000000E.
REQ-030 Signed -7/2 (32'hFFFFFFF9 / 2) -> result_o=64'hFFFFFFFF_FFFFFFFD.
REQ-031 Signed 32'h80000000 / 32'hFFFFFFFF -> result_o=64'h00000000_80000000; unsigned 32'hFFFFFFFF/1 -> 64'h00000000_FFFFFFFF.
REQ-032 Divide by zero (opdata2_i=0) -> ready_o=1 after 2 edges; result_o=0. Dropping start_i -> ready_o=0 one edge later.
REQ-033 annul_i pulsed 10 cycles into ON -> FSM returns to FREE and ready_o never asserts; a new start 12/5 then gives 64'h00000002_00000002.
REQ-034 Async rst asserted mid-ON, between clock edges -> ready_o=0 and result_o=0 immediately; a division after release completes correctly.

Source files
------------

// File: rtl/div.sv
// Iterative 32-bit restoring divider (signed/unsigned) for the EX stage.
// result_o = {remainder, quotient}; one quotient bit per cycle, 33 cycles per divide.
module div (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [64:0] work_q, work_d;
  logic [31:0] divisor_q, divisor_d;
  logic        neg_quo_q, neg_quo_d;
  logic        neg_rem_q, neg_rem_d;
  logic [63:0] result_q, result_d;
  logic        ready_q, ready_d;

  logic [32:0] diff;
  logic [31:0] op1_abs, op2_abs, quo, rem;

  always_comb begin
    op1_abs = (signed_div_i && opdata1_i[31]) ? (~opdata1_i + 32'd1) : opdata1_i;
    op2_abs = (signed_div_i && opdata2_i[31]) ? (~opdata2_i + 32'd1) : opdata2_i;
    diff    = {1'b0, work_q[63:32]} - {1'b0, divisor_q};
    quo     = neg_quo_q ? (~work_q[31:0] + 32'd1)  : work_q[31:0];
    rem     = neg_rem_q ? (~work_q[64:33] + 32'd1) : work_q[64:33];
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    divisor_d = divisor_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    ready_d   = ready_q;
    case (state_q)
      FREE: begin
        ready_d  = 1'b0;
        result_d = '0;
        if (start_i && !annul_i) begin
          divisor_d = op2_abs;
          neg_quo_d = signed_div_i & (opdata1_i[31] ^ opdata2_i[31]);
          neg_rem_d = signed_div_i & opdata1_i[31];
          work_d    = {32'h0, op1_abs, 1'b0};
          cnt_d     = '0;
          state_d   = (opdata2_i == 32'h0) ? BYZERO : ON;
        end
      end
      BYZERO: begin
        result_d = '0;
        ready_d  = 1'b1;
        state_d  = END;
      end
      ON: begin
        if (annul_i) begin
          state_d  = FREE;
          cnt_d    = '0;
          ready_d  = 1'b0;
          result_d = '0;
        end else if (!cnt_q[5]) begin
          // Restoring step: subtract only when the partial remainder covers the divisor.
          work_d = diff[32] ? {work_q[63:0], 1'b0} : {diff[31:0], work_q[31:0], 1'b1};
          cnt_d  = cnt_q + 6'd1;
        end else begin
          result_d = {rem, quo};
          ready_d  = 1'b1;
          state_d  = END;
        end
      end
      END: begin
        if (!start_i) begin
          state_d  = FREE;
          ready_d  = 1'b0;
          result_d = '0;
        end
      end
      default: state_d = FREE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= FREE;
      cnt_q     <= '0;
      work_q    <= '0;
      divisor_q <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_q    <= work_d;
      divisor_q <= divisor_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
      ready_q   <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule
